// File: rtl/mc_datapath_hs_if.sv
// Handshaked external memory port between mc_datapath_hs (master) and the
// system memory/bus (slave).
interface mc_datapath_hs_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic              mem_err;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_err,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_err,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mc_datapath_hs.sv
// Multicycle accumulator datapath with a handshaked memory port and Stall.
// Optional access timeout/abort is built when DP_MEM_TIMEOUT_EN is defined.
//
// state  | meaning
// S_IDLE | no access open; MemRead|MemWrite launches a request
// S_WAIT | request outstanding; leaves on mem_ack (or timeout abort)
module mc_datapath_hs #(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 12,
  parameter int                REG_AW   = 3,
  parameter int                BR_W     = 9,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              AdrSrc, MemRead, MemWrite, IRWrite, MDRWrite,
  input  logic              RegWrite, A3Src, PCWrite, OldPCWrite, ResultSrc,
  input  logic [1:0]        ALUSrcA, ALUSrcB, ImmSrc, PCSrc,
  input  logic [2:0]        ALUControl,
  output logic [3:0]        Op,
  output logic [BR_W-1:0]   Func,
  output logic              Zero,
  output logic              Stall,
  mc_datapath_hs_if.master  mem
);
  localparam int NREG = 2**REG_AW;

  if (DATA_W < ADDR_W + 4) $error("DATA_W must be >= ADDR_W+4");
  if (BR_W >= ADDR_W)      $error("BR_W must be < ADDR_W");
  if (TIMEOUT < 1)         $error("TIMEOUT must be >= 1");

  typedef enum logic {S_IDLE, S_WAIT} st_t;
  st_t state, state_nx;

  logic [ADDR_W-1:0] pc, oldpc, pc_next, adr;
  logic [DATA_W-1:0] ir, mdr, a_q, b_q, aluout;
  logic [DATA_W-1:0] rf [NREG];
  logic [DATA_W-1:0] rd2, wd, imm_ext, src_a, src_b, alu_result;
  logic [REG_AW-1:0] rs2, wa;
  logic              mem_access, req_start, ack_done, tmo, tmo_hit;

  assign mem_access = MemRead | MemWrite;
  assign Op         = ir[DATA_W-1 -: 4];
  assign Func       = ir[BR_W-1:0];
  assign adr        = AdrSrc ? ir[ADDR_W-1:0] : pc;
  assign rs2        = ir[DATA_W-5 -: REG_AW];
  assign wa         = A3Src ? rs2 : '0;
  assign rd2        = rf[rs2];
  assign wd         = ResultSrc ? mdr : aluout;

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= S_IDLE;
    else       state <= state_nx;

  always_comb begin
    state_nx  = state;
    Stall     = 1'b0;
    req_start = 1'b0;
    ack_done  = 1'b0;
    tmo       = 1'b0;
    case (state)
      S_IDLE: if (mem_access) begin
        state_nx  = S_WAIT;
        Stall     = 1'b1;
        req_start = 1'b1;
      end
      S_WAIT: if (mem.mem_ack) begin
        state_nx = S_IDLE;
        ack_done = 1'b1;
      end else if (tmo_hit) begin
        state_nx = S_IDLE;
        tmo      = 1'b1;
      end else begin
        Stall = 1'b1;
      end
      default: state_nx = S_IDLE;
    endcase
    if (reset) Stall = 1'b0;
  end

  // Both strobes high is a write: mem_we follows MemWrite alone.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
    end else if (req_start) begin
      mem.mem_req   <= 1'b1;
      mem.mem_we    <= MemWrite;
      mem.mem_addr  <= adr;
      mem.mem_wdata <= a_q;
    end else if (ack_done | tmo) begin
      mem.mem_req   <= 1'b0;
    end

`ifdef DP_MEM_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  logic [CNT_W-1:0] wait_cnt;
  logic             err_q;

  // Abort lands on the TIMEOUT-th WAIT cycle, i.e. when the count reads TIMEOUT-1.
  assign tmo_hit     = (wait_cnt == CNT_W'(TIMEOUT - 1));
  assign mem.mem_err = err_q;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (req_start)             wait_cnt <= '0;
      else if (state == S_WAIT)  wait_cnt <= wait_cnt + 1'b1;
      if (tmo)                   err_q    <= 1'b1;
    end
`else
  assign tmo_hit     = 1'b0;
  assign mem.mem_err = 1'b0;
`endif

  always_comb begin
    imm_ext = '0;
    case (ImmSrc)
      2'd0: imm_ext = {{(DATA_W-BR_W){ir[BR_W-1]}}, ir[BR_W-1:0]};
      2'd1: imm_ext = {{(DATA_W-BR_W){1'b0}}, ir[BR_W-1:0]};
      2'd2: imm_ext = {{(DATA_W-ADDR_W){1'b0}}, ir[ADDR_W-1:0]};
      default: imm_ext = '0;
    endcase
  end

  always_comb begin
    src_a = '0;
    case (ALUSrcA)
      2'd0: src_a = {{(DATA_W-ADDR_W){1'b0}}, pc};
      2'd1: src_a = {{(DATA_W-ADDR_W){1'b0}}, oldpc};
      2'd2: src_a = a_q;
      default: src_a = '0;
    endcase
    src_b = '0;
    case (ALUSrcB)
      2'd0: src_b = b_q;
      2'd1: src_b = {{(DATA_W-1){1'b0}}, 1'b1};
      2'd2: src_b = imm_ext;
      default: src_b = '0;
    endcase
  end

  always_comb begin
    alu_result = '0;
    case (ALUControl)
      3'b000: alu_result = src_a + src_b;
      3'b001: alu_result = src_a - src_b;
      3'b010: alu_result = src_a & src_b;
      3'b011: alu_result = src_a | src_b;
      3'b100: alu_result = src_a ^ src_b;
      3'b101: alu_result = src_b;
      default: alu_result = '0;
    endcase
  end

  assign Zero = (alu_result == '0);

  always_comb begin
    pc_next = pc;
    case (PCSrc)
      2'd0: pc_next = alu_result[ADDR_W-1:0];
      2'd1: pc_next = ir[ADDR_W-1:0];
      2'd2: pc_next = {oldpc[ADDR_W-1:BR_W], ir[BR_W-1:0]};
      default: pc_next = pc;
    endcase
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (RegWrite & ~Stall) begin
      rf[wa] <= wd;
    end

  // IR/MDR only ever load from memory, so they commit solely on the ack edge.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pc     <= RESET_PC;
      oldpc  <= '0;
      ir     <= '0;
      mdr    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      aluout <= '0;
    end else begin
      if (PCWrite & ~Stall)    pc    <= pc_next;
      if (OldPCWrite & ~Stall) oldpc <= pc;
      if (IRWrite & ack_done)  ir    <= mem.mem_rdata;
      if (MDRWrite & ack_done) mdr   <= mem.mem_rdata;
      if (~Stall) begin
        a_q    <= rf[0];
        b_q    <= rd2;
        aluout <= alu_result;
      end
    end
endmodule
